// File: rtl/async_lock_pkg.sv
// Shared types for the asynchronous-mutex client family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package async_lock_pkg;

  // Default depth for every clock-crossing synchronizer in this family.
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_REL_TO  = 3'd4
  } lock_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-flop single-bit synchronizer for signals asynchronous to clk.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; free-running.
//
// Ports: clk, rst_n (async active-low, clears every stage), d (async input),
//        q (synchronized output).
module sync_ff
  import async_lock_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/mutex_client.sv
// Requester-side 4-phase controller for an asynchronous NAND mutex.
// Latency: req rises 1 cycle after accept; grant seen SYNC_STAGES+1 cycles after gnt.
// Backpressure: acq_ready low outside IDLE or while a grant is still visible.
//
// Ports: clk, rst_n (async active-low); acq_valid/acq_ready acquisition handshake;
//        hold_cycles (latched on accept); rel (early release, used in HOLD only);
//        req/gnt to and from the mutex; held, done, timeout status; grant_count.
module mutex_client
  import async_lock_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD_W      = 8,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acq_valid,
  output logic              acq_ready,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              rel,
  output logic              req,
  input  logic              gnt,
  output logic              held,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  grant_count
);

  // The wait counter serves both the REQ timeout and the REL_TO settle window.
  localparam int WAIT_MAX = (TIMEOUT > SYNC_STAGES) ? TIMEOUT : SYNC_STAGES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int WARM_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] SETTLE  = WAIT_W'(SYNC_STAGES);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);
  localparam bit TO_EN = (TIMEOUT != 0);

  lock_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm;
  logic              gnt_s;
  logic              accept;
  logic              grant_d, done_d, to_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_gnt_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gnt),
    .q     (gnt_s)
  );

  // The synchronizer is cleared by reset, so its output says nothing about a
  // grant still held by the mutex until it has been refilled. Keep acq_ready
  // off until SYNC_STAGES clean samples have passed through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     warm_cnt <= '0;
    else if (!warm) warm_cnt <= warm_cnt + WARM_W'(1);
  end
  assign warm = (warm_cnt == WARM_DONE);

  assign acq_ready = (state_q == ST_IDLE) & ~gnt_s & warm;
  assign accept    = acq_valid & acq_ready;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    wcnt_d  = '0;
    grant_d = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          hcnt_d  = hold_cycles;
        end
      end
      ST_REQ: begin
        if (gnt_s) begin
          state_d = ST_HOLD;
          grant_d = 1'b1;
        end else if (TO_EN && (wcnt_q == TO_LAST)) begin
          state_d = ST_REL_TO;
          to_d    = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      ST_HOLD: begin
        if ((hcnt_q == '0) || rel) state_d = ST_RELEASE;
        else                       hcnt_d  = hcnt_q - HOLD_W'(1);
      end
      ST_RELEASE: begin
        if (!gnt_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_REL_TO: begin
        // A grant racing the falling req can reach gnt_s up to SYNC_STAGES
        // cycles after entry; a low gnt_s is only trusted after that window.
        if (wcnt_q < SETTLE)  wcnt_d  = wcnt_q + WAIT_W'(1);
        else if (!gnt_s)      state_d = ST_IDLE;
        else                  wcnt_d  = wcnt_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs come straight from flops decoded off the next state, so req is
  // glitch-free and changes only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
      wcnt_q      <= '0;
      req         <= 1'b0;
      held        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      grant_count <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      wcnt_q  <= wcnt_d;
      req     <= (state_d == ST_REQ) || (state_d == ST_HOLD);
      held    <= (state_d == ST_HOLD);
      done    <= done_d;
      timeout <= to_d;
      if (grant_d) grant_count <= grant_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mutex_client.sv
module tb_mutex_client;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int held_len;
    int done_n;
    int to_n;
    int count;
  } exp_t;
  exp_t sb_q[$];

  // Clients a and b share a behavioural mutex; client t has TIMEOUT=10 and a
  // grant driven directly by the bench.
  logic       acq_valid_a, acq_ready_a, rel_a, req_a, gnt_a, held_a, done_a, timeout_a;
  logic [7:0] hold_a, grant_count_a;
  logic       acq_valid_b, acq_ready_b, rel_b, req_b, gnt_b, held_b, done_b, timeout_b;
  logic [7:0] hold_b, grant_count_b;
  logic       acq_valid_t, acq_ready_t, rel_t, req_t, gnt_t, held_t, done_t, timeout_t;
  logic [7:0] hold_t, grant_count_t;

  mutex_client u_a (
    .clk(clk), .rst_n(rst_n), .acq_valid(acq_valid_a), .acq_ready(acq_ready_a),
    .hold_cycles(hold_a), .rel(rel_a), .req(req_a), .gnt(gnt_a), .held(held_a),
    .done(done_a), .timeout(timeout_a), .grant_count(grant_count_a)
  );
  mutex_client u_b (
    .clk(clk), .rst_n(rst_n), .acq_valid(acq_valid_b), .acq_ready(acq_ready_b),
    .hold_cycles(hold_b), .rel(rel_b), .req(req_b), .gnt(gnt_b), .held(held_b),
    .done(done_b), .timeout(timeout_b), .grant_count(grant_count_b)
  );
  mutex_client #(.TIMEOUT(10)) u_t (
    .clk(clk), .rst_n(rst_n), .acq_valid(acq_valid_t), .acq_ready(acq_ready_t),
    .hold_cycles(hold_t), .rel(rel_t), .req(req_t), .gnt(gnt_t), .held(held_t),
    .done(done_t), .timeout(timeout_t), .grant_count(grant_count_t)
  );

  // Behavioural mutex: owner keeps the grant while its req stays high; a free
  // mutex grants a first, then b. Grants appear one cycle after req.
  logic own_a = 1'b0, own_b = 1'b0, force_a = 1'b0;
  logic na, nb;
  always_comb begin
    na = own_a & req_a;
    nb = own_b & req_b;
    if (!na && !nb) begin
      if (req_a)      na = 1'b1;
      else if (req_b) nb = 1'b1;
    end
  end
  always @(posedge clk) begin
    own_a <= na;
    own_b <= nb;
  end
  assign gnt_a = own_a | force_a;
  assign gnt_b = own_b;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_a, held_a, done_a, timeout_a, acq_ready_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs_a: got %b expected 00000", {req_a, held_a, done_a, timeout_a, acq_ready_a});
    end
    n_checks++;
    if ({grant_count_a, grant_count_t} !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %h expected 0000", {grant_count_a, grant_count_t});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (acq_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_early: got %b expected 0", acq_ready_a);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({acq_ready_a, acq_ready_b, acq_ready_t} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 111", {acq_ready_a, acq_ready_b, acq_ready_t});
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int nh = 0, nd = 0;
    bit fin = 0;
    acq_valid_a = 1'b1; hold_a = 8'd3;
    e.held_len = 4; e.done_n = 1; e.to_n = 0; e.count = 1;
    sb_q.push_back(e);
    @(negedge clk);
    acq_valid_a = 1'b0;
    n_checks++;
    if ({req_a, acq_ready_a} !== 2'b10) begin
      n_fail++; $display("FAIL basic_req_after_accept: got %b expected 10", {req_a, acq_ready_a});
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (held_a) nh++;
      if (done_a) nd++;
      if (nd > 0 && acq_ready_a) begin fin = 1; break; end
    end
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL basic_bound: got no completion expected done+ready"); end
    e = sb_q.pop_front();
    n_checks++;
    if (nh != e.held_len) begin n_fail++; $display("FAIL basic_held_len: got %0d expected %0d", nh, e.held_len); end
    n_checks++;
    if (nd != e.done_n) begin n_fail++; $display("FAIL basic_done: got %0d expected %0d", nd, e.done_n); end
    n_checks++;
    if (int'(grant_count_a) != e.count) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", grant_count_a, e.count); end
    @(negedge clk);
    n_checks++;
    if ({done_a, req_a, acq_ready_a} !== 3'b001) begin
      n_fail++; $display("FAIL basic_after: got %b expected 001", {done_a, req_a, acq_ready_a});
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int overlap = 0, nha = 0, nhb = 0, nda = 0, ndb = 0;
    int a_first = -1, b_first = -1, a_fall = -1, b_fall = -1;
    bit fin = 0, order_ok;
    do_reset();
    acq_valid_a = 1'b1; acq_valid_b = 1'b1; hold_a = 8'd2; hold_b = 8'd2;
    e.held_len = 3; e.done_n = 1; e.to_n = 0; e.count = 1;
    sb_q.push_back(e); sb_q.push_back(e);
    @(negedge clk);
    acq_valid_a = 1'b0; acq_valid_b = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (held_a && held_b) overlap++;
      if (held_a) begin nha++; if (a_first < 0) a_first = k; end
      if (held_b) begin nhb++; if (b_first < 0) b_first = k; end
      if (a_first >= 0 && !req_a && a_fall < 0) a_fall = k;
      if (b_first >= 0 && !req_b && b_fall < 0) b_fall = k;
      if (done_a) nda++;
      if (done_b) ndb++;
      if (nda > 0 && ndb > 0 && acq_ready_a && acq_ready_b) begin fin = 1; break; end
    end
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL cont_bound: got no completion expected both done"); end
    n_checks++;
    if (overlap != 0) begin n_fail++; $display("FAIL cont_exclusion: got %0d overlapping cycles expected 0", overlap); end
    if (a_first < 0 || b_first < 0)  order_ok = 0;
    else if (a_first < b_first)      order_ok = (a_fall >= 0) && (b_first > a_fall);
    else                             order_ok = (b_fall >= 0) && (a_first > b_fall);
    n_checks++;
    if (!order_ok) begin
      n_fail++; $display("FAIL cont_order: got held a@%0d b@%0d fall a@%0d b@%0d expected second held after first req fall", a_first, b_first, a_fall, b_fall);
    end
    e = sb_q.pop_front();
    n_checks++;
    if (nha != e.held_len || nda != e.done_n || int'(grant_count_a) != e.count) begin
      n_fail++; $display("FAIL cont_a: got held %0d done %0d count %0d expected %0d %0d %0d", nha, nda, grant_count_a, e.held_len, e.done_n, e.count);
    end
    e = sb_q.pop_front();
    n_checks++;
    if (nhb != e.held_len || ndb != e.done_n || int'(grant_count_b) != e.count) begin
      n_fail++; $display("FAIL cont_b: got held %0d done %0d count %0d expected %0d %0d %0d", nhb, ndb, grant_count_b, e.held_len, e.done_n, e.count);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int to_at = -1, nto = 0, nh = 0, nd = 0;
    logic req_at_to = 1'b1;
    gnt_t = 1'b0;
    acq_valid_t = 1'b1; hold_t = 8'd5;
    e.held_len = 0; e.done_n = 0; e.to_n = 1; e.count = 0;
    sb_q.push_back(e);
    @(negedge clk);
    acq_valid_t = 1'b0;
    n_checks++;
    if (req_t !== 1'b1) begin n_fail++; $display("FAIL to_req_rise: got %b expected 1", req_t); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeout_t) begin
        nto++;
        if (to_at < 0) begin to_at = k; req_at_to = req_t; end
      end
      if (held_t) nh++;
      if (done_t) nd++;
    end
    n_checks++;
    if (to_at != 10) begin n_fail++; $display("FAIL to_latency: got %0d expected 10", to_at); end
    n_checks++;
    if (req_at_to !== 1'b0) begin n_fail++; $display("FAIL to_req_low: got %b expected 0", req_at_to); end
    e = sb_q.pop_front();
    n_checks++;
    if (nto != e.to_n || nh != e.held_len || nd != e.done_n || int'(grant_count_t) != e.count) begin
      n_fail++; $display("FAIL to_counts: got to %0d held %0d done %0d count %0d expected %0d %0d %0d %0d", nto, nh, nd, grant_count_t, e.to_n, e.held_len, e.done_n, e.count);
    end
    n_checks++;
    if (acq_ready_t !== 1'b1) begin n_fail++; $display("FAIL to_idle: got ready %b expected 1", acq_ready_t); end
  endtask

  task automatic test_race();
    exp_t e;
    int to_at = -1, nto = 0, nh = 0, nd = 0, early = 0;
    acq_valid_t = 1'b1; hold_t = 8'd5;
    e.held_len = 0; e.done_n = 0; e.to_n = 1; e.count = 0;
    sb_q.push_back(e);
    @(negedge clk);
    acq_valid_t = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (timeout_t) begin nto++; if (to_at < 0) to_at = k; end
      if (held_t) nh++;
      if (done_t) nd++;
      if (acq_ready_t && k <= 14) early++;
      // Grant lands on the same edge the timed-out req falls, then the mutex
      // withdraws it a few cycles later.
      if (k == 9)  gnt_t = 1'b1;
      if (k == 12) gnt_t = 1'b0;
    end
    n_checks++;
    if (to_at != 10) begin n_fail++; $display("FAIL race_to_latency: got %0d expected 10", to_at); end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL race_left_rel_to: got %0d ready cycles expected 0", early); end
    e = sb_q.pop_front();
    n_checks++;
    if (nto != e.to_n || nh != e.held_len || nd != e.done_n || int'(grant_count_t) != e.count) begin
      n_fail++; $display("FAIL race_counts: got to %0d held %0d done %0d count %0d expected %0d %0d %0d %0d", nto, nh, nd, grant_count_t, e.to_n, e.held_len, e.done_n, e.count);
    end
    n_checks++;
    if ({acq_ready_t, req_t} !== 2'b10) begin n_fail++; $display("FAIL race_idle: got %b expected 10", {acq_ready_t, req_t}); end
  endtask

  task automatic test_early_release();
    exp_t e;
    int nh = 0, nd = 0, r_idx = -1, d_idx = -1;
    bit fin = 0;
    do_reset();
    acq_valid_a = 1'b1; hold_a = 8'd200;
    e.held_len = 5; e.done_n = 1; e.to_n = 0; e.count = 1;
    sb_q.push_back(e);
    @(negedge clk);
    acq_valid_a = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (held_a) nh++;
      if (done_a) begin nd++; d_idx = k; end
      if (rel_a) begin
        rel_a = 1'b0;
        r_idx = k;
        n_checks++;
        if ({held_a, req_a} !== 2'b00) begin
          n_fail++; $display("FAIL rel_drop: got held/req %b expected 00", {held_a, req_a});
        end
      end else if (held_a && nh == 5) begin
        rel_a = 1'b1;
      end
      if (nd > 0 && acq_ready_a) begin fin = 1; break; end
    end
    n_checks++;
    if (!fin || r_idx < 0) begin n_fail++; $display("FAIL rel_bound: got fin %0d rel@%0d expected completion", fin, r_idx); end
    e = sb_q.pop_front();
    n_checks++;
    if (nh != e.held_len || nd != e.done_n || int'(grant_count_a) != e.count) begin
      n_fail++; $display("FAIL rel_counts: got held %0d done %0d count %0d expected %0d %0d %0d", nh, nd, grant_count_a, e.held_len, e.done_n, e.count);
    end
    n_checks++;
    if (d_idx - r_idx < 3) begin n_fail++; $display("FAIL rel_done_wait: got %0d cycles expected >= 3", d_idx - r_idx); end
  endtask

  task automatic test_reset_hold();
    int ready_hi = 0;
    bit got = 0;
    do_reset();
    acq_valid_a = 1'b1; hold_a = 8'd50;
    @(negedge clk);
    acq_valid_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (held_a) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rh_bound: got no held expected held"); end
    repeat (2) @(negedge clk);
    force_a = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_a, held_a, done_a, timeout_a, acq_ready_a, grant_count_a} !== 13'd0) begin
      n_fail++; $display("FAIL rh_clear: got %b expected all 0", {req_a, held_a, done_a, timeout_a, acq_ready_a, grant_count_a});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (acq_ready_a) ready_hi++;
    end
    force_a = 1'b0;
    @(negedge clk);
    if (acq_ready_a) ready_hi++;
    n_checks++;
    if (ready_hi != 0) begin n_fail++; $display("FAIL rh_ready_stale: got %0d ready cycles expected 0", ready_hi); end
    @(negedge clk);
    n_checks++;
    if (acq_ready_a !== 1'b1) begin n_fail++; $display("FAIL rh_ready_return: got %b expected 1", acq_ready_a); end
  endtask

  initial begin
    rst_n = 1'b0;
    acq_valid_a = 1'b0; hold_a = '0; rel_a = 1'b0;
    acq_valid_b = 1'b0; hold_b = '0; rel_b = 1'b0;
    acq_valid_t = 1'b0; hold_t = '0; rel_t = 1'b0; gnt_t = 1'b0;
    test_reset();
    test_basic();
    test_contention();
    test_timeout();
    test_race();
    test_early_release();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
